// File: rtl/segment_transition_ctrl.sv
// rtl/segment_transition_ctrl.sv - read-segment swap scheduler for a double-buffered sequence
//
// Purpose:
//   Latches one settings update (target segment, trigger mode, trigger value)
//   and holds it until its trigger fires. When the trigger fires, it swaps the
//   active read segment and restarts the index timer. It also counts completed
//   loops of the active segment. When finite repetition runs out, it either
//   stops the sampler or auto-toggles the segment (EXT mode).
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   UPDATE            one-cycle settings strobe
//   REQ_RD_SEGMENT    requested segment
//   TRANSITION_MODE   trigger select (SYNC_IDX/SYS_TIME/GPIO/EXT/IMMEDIATE)
//   TRANSITION_VALUE  SYS_TIME target or GPIO bit select
//   REP0, REP1        loops-1 per segment, 0xFFFF = infinite
//   SYS_TIME          free-running system time
//   GPIO_IN           synchronised external triggers
//   IDX_WRAP          end-of-cycle pulse from the index timer
//   SEGMENT           active read segment
//   LOOP_CNT          completed loops of the active segment
//   STOP              finite repetition exhausted
//   PENDING           request latched, waiting for its trigger
//   IDX_RST           one-cycle pulse restarting the index timer
module segment_transition_ctrl #(
  parameter int GPIO_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UPDATE,
  input  logic              REQ_RD_SEGMENT,
  input  logic [7:0]        TRANSITION_MODE,
  input  logic [63:0]       TRANSITION_VALUE,
  input  logic [15:0]       REP0,
  input  logic [15:0]       REP1,
  input  logic [63:0]       SYS_TIME,
  input  logic [GPIO_W-1:0] GPIO_IN,
  input  logic              IDX_WRAP,
  output logic              SEGMENT,
  output logic [15:0]       LOOP_CNT,
  output logic              STOP,
  output logic              PENDING,
  output logic              IDX_RST
);

  localparam logic [7:0]  MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0]  MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0]  MODE_GPIO      = 8'h02;
  localparam logic [7:0]  MODE_EXT       = 8'hF0;
  localparam logic [7:0]  MODE_IMMEDIATE = 8'hFF;
  localparam logic [15:0] REP_INFINITE   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                segment_q, segment_d;
  logic [15:0]         loop_cnt_q, loop_cnt_d;
  logic                stop_q, stop_d;
  logic                pending_q, pending_d;
  logic                idx_rst_q, idx_rst_d;
  logic                lat_seg_q, lat_seg_d;
  logic [7:0]          lat_mode_q, lat_mode_d;
  logic [63:0]         lat_value_q, lat_value_d;
  logic [GPIO_W-1:0]   gpio_prev_q, gpio_prev_d;

  logic [15:0]         rep_sel;
  logic [GPIO_W-1:0]   gpio_rise;
  logic                trig;
  logic                fire;
  logic                wrap_active;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      segment_q   <= 1'b0;
      loop_cnt_q  <= 16'd0;
      stop_q      <= 1'b0;
      pending_q   <= 1'b0;
      idx_rst_q   <= 1'b0;
      lat_seg_q   <= 1'b0;
      lat_mode_q  <= MODE_IMMEDIATE;
      lat_value_q <= 64'd0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      segment_q   <= segment_d;
      loop_cnt_q  <= loop_cnt_d;
      stop_q      <= stop_d;
      pending_q   <= pending_d;
      idx_rst_q   <= idx_rst_d;
      lat_seg_q   <= lat_seg_d;
      lat_mode_q  <= lat_mode_d;
      lat_value_q <= lat_value_d;
      gpio_prev_q <= gpio_prev_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    segment_d   = segment_q;
    loop_cnt_d  = loop_cnt_q;
    stop_d      = stop_q;
    pending_d   = pending_q;
    idx_rst_d   = 1'b0;
    lat_seg_d   = lat_seg_q;
    lat_mode_d  = lat_mode_q;
    lat_value_d = lat_value_q;
    gpio_prev_d = GPIO_IN;

    rep_sel   = segment_q ? REP1 : REP0;
    gpio_rise = GPIO_IN & ~gpio_prev_q;

    case (lat_mode_q)
      MODE_IMMEDIATE: trig = 1'b1;
      MODE_SYNC_IDX:  trig = IDX_WRAP;
      MODE_EXT:       trig = IDX_WRAP;
      MODE_SYS_TIME:  trig = (SYS_TIME >= lat_value_q);
      MODE_GPIO:      trig = gpio_rise[lat_value_q[1:0]];
      default:        trig = 1'b0;
    endcase

    // A fresh UPDATE pre-empts the trigger of the request it replaces.
    fire = (state_q == ST_WAIT) && !UPDATE && trig;

    // While stopped the timer is held, so stray wraps are not counted.
    wrap_active = IDX_WRAP && (state_q != ST_HALT) && !stop_q;

    if (fire) begin
      // The wrap that caused or coincided with the swap belongs to the old segment.
      segment_d  = lat_seg_q;
      loop_cnt_d = 16'd0;
      stop_d     = 1'b0;
      pending_d  = 1'b0;
      idx_rst_d  = 1'b1;
      state_d    = ST_RUN;
    end else begin
      if (wrap_active) begin
        if ((rep_sel != REP_INFINITE) && (loop_cnt_q == rep_sel)) begin
          if (lat_mode_q == MODE_EXT) begin
            segment_d  = ~segment_q;
            loop_cnt_d = 16'd0;
            idx_rst_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
            // A pending request keeps WAIT alive so its trigger can still fire.
            if (state_q == ST_RUN) begin
              state_d = ST_HALT;
            end
          end
        end else if (loop_cnt_q != 16'hFFFF) begin
          loop_cnt_d = loop_cnt_q + 16'd1;
        end
      end

      if (UPDATE) begin
        lat_seg_d   = REQ_RD_SEGMENT;
        lat_mode_d  = TRANSITION_MODE;
        lat_value_d = TRANSITION_VALUE;
        pending_d   = 1'b1;
        state_d     = ST_WAIT;
      end
    end
  end

  // Outputs come straight from flops
  always_comb begin
    SEGMENT  = segment_q;
    LOOP_CNT = loop_cnt_q;
    STOP     = stop_q;
    PENDING  = pending_q;
    IDX_RST  = idx_rst_q;
  end

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// tb/tb_segment_transition_ctrl.sv - directed-vector bench for segment_transition_ctrl
module tb_segment_transition_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        UPDATE = 1'b0;
  logic        REQ_RD_SEGMENT = 1'b0;
  logic [7:0]  TRANSITION_MODE = 8'h00;
  logic [63:0] TRANSITION_VALUE = 64'd0;
  logic [15:0] REP0 = 16'hFFFF;
  logic [15:0] REP1 = 16'hFFFF;
  logic [63:0] SYS_TIME = 64'd0;
  logic [3:0]  GPIO_IN = 4'd0;
  logic        IDX_WRAP = 1'b0;
  logic        SEGMENT;
  logic [15:0] LOOP_CNT;
  logic        STOP;
  logic        PENDING;
  logic        IDX_RST;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  segment_transition_ctrl #(.GPIO_W(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .UPDATE           (UPDATE),
    .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
    .TRANSITION_MODE  (TRANSITION_MODE),
    .TRANSITION_VALUE (TRANSITION_VALUE),
    .REP0             (REP0),
    .REP1             (REP1),
    .SYS_TIME         (SYS_TIME),
    .GPIO_IN          (GPIO_IN),
    .IDX_WRAP         (IDX_WRAP),
    .SEGMENT          (SEGMENT),
    .LOOP_CNT         (LOOP_CNT),
    .STOP             (STOP),
    .PENDING          (PENDING),
    .IDX_RST          (IDX_RST)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic upd(input logic seg, input logic [7:0] mode, input logic [63:0] val);
    UPDATE           = 1'b1;
    REQ_RD_SEGMENT   = seg;
    TRANSITION_MODE  = mode;
    TRANSITION_VALUE = val;
    step();
    UPDATE = 1'b0;
  endtask

  task automatic wrap();
    IDX_WRAP = 1'b1;
    step();
    IDX_WRAP = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_seg", 64'(SEGMENT), 64'd0);
    chk("rst_loop", 64'(LOOP_CNT), 64'd0);
    chk("rst_stop", 64'(STOP), 64'd0);
    chk("rst_pend", 64'(PENDING), 64'd0);
    chk("rst_idxrst", 64'(IDX_RST), 64'd0);
    RST = 1'b0;
    step();

    // IMMEDIATE: UPDATE at n, switch visible at n+2
    upd(1'b1, 8'hFF, 64'd0);
    chk("imm_pend_n1", 64'(PENDING), 64'd1);
    chk("imm_seg_n1", 64'(SEGMENT), 64'd0);
    step();
    chk("imm_seg_n2", 64'(SEGMENT), 64'd1);
    chk("imm_idxrst_n2", 64'(IDX_RST), 64'd1);
    chk("imm_pend_n2", 64'(PENDING), 64'd0);
    step();
    chk("imm_idxrst_n3", 64'(IDX_RST), 64'd0);

    // SYS_TIME future target: fires on the edge where SYS_TIME reaches 1000
    SYS_TIME = 64'd990;
    upd(1'b0, 8'h01, 64'd1000);
    for (int t = 991; t <= 1000; t++) begin
      SYS_TIME = 64'(t);
      step();
      if (t < 1000) begin
        chk("st_wait_seg", 64'(SEGMENT), 64'd1);
        chk("st_wait_pend", 64'(PENDING), 64'd1);
      end else begin
        chk("st_fire_seg", 64'(SEGMENT), 64'd0);
        chk("st_fire_idxrst", 64'(IDX_RST), 64'd1);
      end
    end
    // SYS_TIME past target: fires on the first WAIT cycle
    SYS_TIME = 64'd990;
    upd(1'b1, 8'h01, 64'd5);
    chk("stp_pend", 64'(PENDING), 64'd1);
    chk("stp_seg0", 64'(SEGMENT), 64'd0);
    step();
    chk("stp_seg1", 64'(SEGMENT), 64'd1);
    chk("stp_idxrst", 64'(IDX_RST), 64'd1);

    // Finite repetition REP1=2
    REP1 = 16'd2;
    upd(1'b1, 8'hFF, 64'd0);
    step();
    chk("rep_seg", 64'(SEGMENT), 64'd1);
    chk("rep_loop0", 64'(LOOP_CNT), 64'd0);
    wrap();
    chk("rep_loop1", 64'(LOOP_CNT), 64'd1);
    chk("rep_stop1", 64'(STOP), 64'd0);
    wrap();
    chk("rep_loop2", 64'(LOOP_CNT), 64'd2);
    chk("rep_stop2", 64'(STOP), 64'd0);
    wrap();
    chk("rep_stop3", 64'(STOP), 64'd1);
    chk("rep_loop3", 64'(LOOP_CNT), 64'd2);
    wrap();
    chk("rep_stop4", 64'(STOP), 64'd1);
    chk("rep_loop4", 64'(LOOP_CNT), 64'd2);
    upd(1'b0, 8'hFF, 64'd0);
    chk("rep_upd_stop", 64'(STOP), 64'd1);
    chk("rep_upd_pend", 64'(PENDING), 64'd1);
    step();
    chk("rep_clr_stop", 64'(STOP), 64'd0);
    chk("rep_clr_seg", 64'(SEGMENT), 64'd0);
    chk("rep_clr_loop", 64'(LOOP_CNT), 64'd0);

    // EXT with REP0=REP1=0: every wrap toggles the segment
    REP0 = 16'd0;
    REP1 = 16'd0;
    upd(1'b0, 8'hF0, 64'd0);
    chk("ext_pend", 64'(PENDING), 64'd1);
    wrap();
    chk("ext_sw_seg", 64'(SEGMENT), 64'd0);
    chk("ext_sw_idxrst", 64'(IDX_RST), 64'd1);
    chk("ext_sw_pend", 64'(PENDING), 64'd0);
    step();
    chk("ext_idle_idxrst", 64'(IDX_RST), 64'd0);
    wrap();
    chk("ext_t1_seg", 64'(SEGMENT), 64'd1);
    chk("ext_t1_idxrst", 64'(IDX_RST), 64'd1);
    chk("ext_t1_stop", 64'(STOP), 64'd0);
    step();
    wrap();
    chk("ext_t2_seg", 64'(SEGMENT), 64'd0);
    chk("ext_t2_idxrst", 64'(IDX_RST), 64'd1);
    chk("ext_t2_stop", 64'(STOP), 64'd0);
    REP0 = 16'hFFFF;
    REP1 = 16'hFFFF;
    step();

    // GPIO bit 2: level held high is not an edge; other bits are ignored
    GPIO_IN = 4'b0100;
    step();
    upd(1'b1, 8'h02, 64'd2);
    chk("gpio_pend", 64'(PENDING), 64'd1);
    step();
    chk("gpio_held_seg", 64'(SEGMENT), 64'd0);
    chk("gpio_held_pend", 64'(PENDING), 64'd1);
    GPIO_IN = 4'b0000;
    step();
    GPIO_IN = 4'b0001;
    step();
    chk("gpio_bit0_seg", 64'(SEGMENT), 64'd0);
    chk("gpio_bit0_pend", 64'(PENDING), 64'd1);
    GPIO_IN = 4'b0101;
    step();
    chk("gpio_edge_seg", 64'(SEGMENT), 64'd1);
    chk("gpio_edge_idxrst", 64'(IDX_RST), 64'd1);
    chk("gpio_edge_pend", 64'(PENDING), 64'd0);

    // Unknown mode never fires; wrap still counts
    upd(1'b0, 8'h55, 64'd0);
    wrap();
    step();
    chk("bad_mode_pend", 64'(PENDING), 64'd1);
    chk("bad_mode_seg", 64'(SEGMENT), 64'd1);
    chk("bad_mode_loop", 64'(LOOP_CNT), 64'd1);

    // Replace: SYNC_IDX pending, new UPDATE with a coincident wrap wins, far SYS_TIME never fires
    upd(1'b0, 8'h00, 64'd0);
    SYS_TIME = 64'd990;
    IDX_WRAP = 1'b1;
    upd(1'b0, 8'h01, 64'hFFFF_FFFF_FFFF_0000);
    IDX_WRAP = 1'b0;
    chk("repl_seg", 64'(SEGMENT), 64'd1);
    chk("repl_idxrst", 64'(IDX_RST), 64'd0);
    wrap();
    chk("repl_wrap_seg", 64'(SEGMENT), 64'd1);
    chk("repl_wrap_pend", 64'(PENDING), 64'd1);
    chk("repl_wrap_loop", 64'(LOOP_CNT), 64'd3);
    RST = 1'b1;
    step();
    chk("mid_rst_pend", 64'(PENDING), 64'd0);
    chk("mid_rst_seg", 64'(SEGMENT), 64'd0);
    chk("mid_rst_loop", 64'(LOOP_CNT), 64'd0);
    RST = 1'b0;
    step();
    step();
    chk("post_rst_pend", 64'(PENDING), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
